msrv32_machine_control: RTL and testbench
=========================================

# msrv32_machine_control

Trap and privileged-flow controller for the msrv32 core. It decodes exceptions, qualified interrupts and MRET from the current instruction and the CSR file's enable/pending bits, runs the reset/trap/return state machine, and drives the CSR file's trap strobes (set_cause, set_epc, i_or_e, cause, mie_clear/mie_set, instret_inc, misaligned_exception). It also drives the PC-mux select and pipeline flush. It sits directly upstream of msrv32_csr_file, alongside the PC mux and decoder.

## Interface
- No parameters.
- clk_in  input  1  core clock; all state updates on rising edge
- rst_in  input  1  reset, synchronous, active-low
- illegal_instr_in  input  1  decoder flagged illegal instruction
- misaligned_instr_in  input  1  fetch target misaligned
- misaligned_load_in  input  1  load address misaligned
- misaligned_store_in  input  1  store address misaligned
- opcode_6_2_in  input  5  instruction bits [6:2]
- funct3_in  input  3  instruction bits [14:12]
- funct7_in  input  7  instruction bits [31:25]
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  instruction register fields
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  mie register enables
- meip_in, mtip_in, msip_in  input  1 each  mip pending bits
- i_or_e_out  output  1  1 = interrupt, 0 = exception (registered)
- cause_out  output  4  trap cause code (registered)
- set_cause_out, set_epc_out  output  1 each  CSR capture strobes
- mie_clear_out, mie_set_out  output  1 each  mstatus.MIE clear/restore strobes
- instret_inc_out  output  1  retire-count increment
- misaligned_exception_out  output  1  trap is an address-misaligned exception (mtval capture)
- pc_src_out  output  2  00 boot, 01 next, 10 epc, 11 trap address
- flush_out  output  1  kill the instruction in the pipeline

## Operation
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- SYSTEM decode applies only when opcode_6_2_in = 5'b11100 and funct3_in = 0. ECALL: funct7 = 0, rs2 = 0, rs1 = 0, rd = 0. EBREAK: same, but rs2 = 1. MRET: funct7 = 7'b0011000, rs2 = 5'b00010, rs1 = 0, rd = 0.
- An exception is any of: misaligned_instr, illegal, EBREAK, ECALL, misaligned_load, misaligned_store.
- Exception priority and cause, highest first:
  - misaligned_instr 0
  - illegal 2
  - EBREAK 3
  - ECALL 11
  - misaligned_load 4
  - misaligned_store 6
- An interrupt is taken when mie_in and any of (meie&meip, msie&msip, mtie&mtip) is set. Priority and cause: external 11 > software 3 > timer 7.
- Exceptions beat interrupts. Either one beats MRET.
- Transitions:
  - RESET → OPERATING, unconditionally.
  - OPERATING → TRAP_TAKEN on exception or interrupt. Cause and i_or_e are registered on this edge. misaligned_exception is registered as 1 iff cause ∈ {0, 4, 6} and i_or_e = 0.
  - OPERATING → TRAP_RETURN on MRET with no trap.
  - TRAP_TAKEN → OPERATING.
  - TRAP_RETURN → OPERATING.
- Outputs by state:
  - RESET: pc_src 00, flush 1, all strobes 0.
  - OPERATING: pc_src 01, flush 0, strobes 0. instret_inc = 1 unless an exception or interrupt is detected that cycle. MRET counts as retired.
  - TRAP_TAKEN: pc_src 11, flush 1, set_epc = set_cause = mie_clear = 1, instret_inc 0.
  - TRAP_RETURN: pc_src 10, flush 1, mie_set 1, other strobes 0.
- Interrupts and exceptions are ignored outside OPERATING. Inputs in TRAP_TAKEN/TRAP_RETURN belong to the flushed instruction.
- cause_out, i_or_e_out and misaligned_exception_out hold their value until the next trap entry.

## Timing
- Reset: when rst_in = 0 at a rising edge, the next state is RESET, cause = 0, i_or_e = 0, misaligned = 0. This applies from any state, mid-trap included; pending strobes drop the cycle after. Outputs then show the RESET values.
- The first cycle after rst_in rises is RESET. OPERATING starts the cycle after that.
- Trap latency: condition in cycle N (OPERATING). TRAP_TAKEN is cycle N+1, with strobes high for exactly one cycle. The CSR file captures mepc/mcause/mtval and clears MIE at the end of N+1. OPERATING at the trap vector is cycle N+2.
- MRET: detected in cycle N, TRAP_RETURN in N+1, OPERATING at mepc in N+2.
- Back-to-back traps: a still-pending interrupt at N+2 re-enters a trap only if mie_in is set. MIE was cleared at N+1, so no re-entry occurs unless the handler sets MIE.
- Simultaneous exception and interrupt: the exception is taken; the interrupt stays pending.
- Combinational paths: instret_inc_out depends on current inputs in OPERATING. All other outputs are functions of state and registers only.

## Test plan
- Reset: hold rst_in = 0 for 3 cycles, then release → pc_src 00, flush 1, cause 0 while low. Then 1 RESET cycle, then pc_src 01 with instret_inc 1.
- ECALL (opcode 11100, all fields 0) in OPERATING → next cycle pc_src 11, cause 11, i_or_e 0, set_epc = set_cause = mie_clear = 1 for one cycle, then pc_src 01.
- illegal_instr and misaligned_load together → cause 2, misaligned_exception_out 0. misaligned_store alone → cause 6, misaligned_exception_out 1.
- mie 1, meie = meip = 1, mtie = mtip = 1 → cause 11, i_or_e 1. Same with mie 0 → no trap, instret_inc 1.
- MRET (funct7 0011000, rs2 00010) → next cycle pc_src 10, mie_set 1, flush 1. MRET with illegal_instr set → trap with cause 2, no mie_set.
- rst_in driven low during TRAP_TAKEN → next cycle RESET outputs, set_cause 0, cause 0.

Source files
------------

// File: rtl/msrv32_machine_control.sv
// msrv32_machine_control
//   Trap and privileged-flow controller. Decodes exceptions, qualified
//   interrupts and MRET from the current instruction and the CSR enable and
//   pending bits. Runs the RESET/OPERATING/TRAP_TAKEN/TRAP_RETURN machine and
//   drives the CSR-file trap strobes, the PC-mux select and pipeline flush.
// Ports
//   clk_in, rst_in            : clock, synchronous active-low reset
//   illegal/misaligned_*_in   : exception sources
//   opcode/funct3/funct7/rs*/rd : instruction fields for ECALL/EBREAK/MRET
//   mie_in, m{e,t,s}ie_in/ip_in : interrupt enables and pending bits
//   i_or_e/cause/misaligned_exception_out : trap info, held until next trap
//   set_cause/set_epc/mie_clear/mie_set/instret_inc_out : CSR strobes
//   pc_src_out (00 boot, 01 next, 10 epc, 11 trap), flush_out
module msrv32_machine_control (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       misaligned_exception_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  state_t     r_state;
  logic [3:0] r_cause;
  logic       r_i_or_e;
  logic       r_misaligned;
  logic [1:0] r_pc_src;
  logic       r_flush;
  logic       r_set_trap;
  logic       r_mie_set;

  // SYSTEM-opcode decode
  logic w_system, w_zero_regs, w_ecall, w_ebreak, w_mret;
  assign w_system    = (opcode_6_2_in == 5'b11100) && (funct3_in == 3'b000);
  assign w_zero_regs = (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign w_ecall     = w_system && w_zero_regs && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
  assign w_ebreak    = w_system && w_zero_regs && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
  assign w_mret      = w_system && w_zero_regs && (funct7_in == 7'b0011000) &&
                       (rs2_addr_in == 5'b00010);

  // Exception detection and priority-encoded cause
  logic       w_exc;
  logic [3:0] w_exc_cause;
  assign w_exc = misaligned_instr_in | illegal_instr_in | w_ebreak | w_ecall |
                 misaligned_load_in | misaligned_store_in;

  always_comb begin
    w_exc_cause = 4'd0;
    if (misaligned_instr_in)     w_exc_cause = 4'd0;
    else if (illegal_instr_in)   w_exc_cause = 4'd2;
    else if (w_ebreak)           w_exc_cause = 4'd3;
    else if (w_ecall)            w_exc_cause = 4'd11;
    else if (misaligned_load_in) w_exc_cause = 4'd4;
    else                         w_exc_cause = 4'd6;
  end

  // Interrupt qualification: global MIE gates all three sources
  logic       w_int_ext, w_int_sw, w_int_tmr, w_int;
  logic [3:0] w_int_cause;
  assign w_int_ext = mie_in & meie_in & meip_in;
  assign w_int_sw  = mie_in & msie_in & msip_in;
  assign w_int_tmr = mie_in & mtie_in & mtip_in;
  assign w_int     = w_int_ext | w_int_sw | w_int_tmr;
  assign w_int_cause = w_int_ext ? 4'd11 : (w_int_sw ? 4'd3 : 4'd7);

  logic       w_trap;
  logic [3:0] w_trap_cause;
  logic       w_misaligned_cause;
  assign w_trap       = w_exc | w_int;
  assign w_trap_cause = w_exc ? w_exc_cause : w_int_cause;
  // mtval capture only for address-misaligned exceptions (causes 0/4/6)
  assign w_misaligned_cause = w_exc && ((w_exc_cause == 4'd0) ||
                              (w_exc_cause == 4'd4) || (w_exc_cause == 4'd6));

  // State machine; pc_src/flush/strobes are registered for the next state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= RESET;
      r_cause      <= 4'd0;
      r_i_or_e     <= 1'b0;
      r_misaligned <= 1'b0;
      r_pc_src     <= 2'b00;
      r_flush      <= 1'b1;
      r_set_trap   <= 1'b0;
      r_mie_set    <= 1'b0;
    end else begin
      // Default: next state is OPERATING
      r_pc_src   <= 2'b01;
      r_flush    <= 1'b0;
      r_set_trap <= 1'b0;
      r_mie_set  <= 1'b0;
      case (r_state)
        OPERATING: begin
          if (w_trap) begin
            r_state      <= TRAP_TAKEN;
            r_cause      <= w_trap_cause;
            r_i_or_e     <= ~w_exc;
            r_misaligned <= w_misaligned_cause;
            r_pc_src     <= 2'b11;
            r_flush      <= 1'b1;
            r_set_trap   <= 1'b1;
          end else if (w_mret) begin
            r_state   <= TRAP_RETURN;
            r_pc_src  <= 2'b10;
            r_flush   <= 1'b1;
            r_mie_set <= 1'b1;
          end else begin
            r_state <= OPERATING;
          end
        end
        default: r_state <= OPERATING;
      endcase
    end
  end

  assign i_or_e_out               = r_i_or_e;
  assign cause_out                = r_cause;
  assign misaligned_exception_out = r_misaligned;
  assign set_cause_out            = r_set_trap;
  assign set_epc_out              = r_set_trap;
  assign mie_clear_out            = r_set_trap;
  assign mie_set_out              = r_mie_set;
  assign pc_src_out               = r_pc_src;
  assign flush_out                = r_flush;
  // Retirement is the only output that looks at the live instruction
  assign instret_inc_out          = (r_state == OPERATING) && !w_trap;

endmodule

// File: tb/tb_msrv32_machine_control.sv
module tb_msrv32_machine_control;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
  logic [4:0] opcode_6_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic       instret_inc_out, misaligned_exception_out, flush_out;
  logic [1:0] pc_src_out;

  always #5 clk_in = ~clk_in;

  msrv32_machine_control dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .opcode_6_2_in(opcode_6_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .i_or_e_out(i_or_e_out), .cause_out(cause_out),
    .set_cause_out(set_cause_out), .set_epc_out(set_epc_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .instret_inc_out(instret_inc_out),
    .misaligned_exception_out(misaligned_exception_out),
    .pc_src_out(pc_src_out), .flush_out(flush_out)
  );

  typedef struct packed {
    logic [1:0] pc_src;
    logic       flush;
    logic       set_cause;
    logic       set_epc;
    logic       mie_clear;
    logic       mie_set;
    logic       instret;
    logic       mis;
    logic [3:0] cause;
    logic       ioe;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a phase name plus the latched trap info
  string m_phase = "RESET";
  int    m_cause = 0;
  bit    m_ioe   = 0;
  bit    m_mis   = 0;

  // Monitor: one expected entry per cycle, sampled mid-cycle
  always @(negedge clk_in) begin
    exp_t a, e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {pc_src_out, flush_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, instret_inc_out, misaligned_exception_out, cause_out, i_or_e_out};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t phase=%s got pc=%b fl=%b sc=%b se=%b mc=%b ms=%b ir=%b mis=%b c=%0d ioe=%b want pc=%b fl=%b sc=%b se=%b mc=%b ms=%b ir=%b mis=%b c=%0d ioe=%b",
          $time, m_phase, a.pc_src, a.flush, a.set_cause, a.set_epc, a.mie_clear, a.mie_set,
          a.instret, a.mis, a.cause, a.ioe, e.pc_src, e.flush, e.set_cause, e.set_epc,
          e.mie_clear, e.mie_set, e.instret, e.mis, e.cause, e.ioe);
      end
    end
  end

  // Computes this cycle's expected outputs from the spec rules, queues them,
  // then advances the model across the coming clock edge.
  task automatic model_step();
    exp_t e;
    bit sys, ecall, ebreak, mret, exc, intr;
    int exc_cause, int_cause;
    sys    = (opcode_6_2_in == 5'b11100) && (funct3_in == 0);
    ecall  = sys && funct7_in == 0 && rs2_addr_in == 0 && rs1_addr_in == 0 && rd_addr_in == 0;
    ebreak = sys && funct7_in == 0 && rs2_addr_in == 1 && rs1_addr_in == 0 && rd_addr_in == 0;
    mret   = sys && funct7_in == 7'b0011000 && rs2_addr_in == 5'b00010 &&
             rs1_addr_in == 0 && rd_addr_in == 0;
    exc_cause = -1;
    if (misaligned_instr_in)     exc_cause = 0;
    else if (illegal_instr_in)   exc_cause = 2;
    else if (ebreak)             exc_cause = 3;
    else if (ecall)              exc_cause = 11;
    else if (misaligned_load_in) exc_cause = 4;
    else if (misaligned_store_in) exc_cause = 6;
    exc = (exc_cause >= 0);
    int_cause = -1;
    if (mie_in) begin
      if (meie_in && meip_in)      int_cause = 11;
      else if (msie_in && msip_in) int_cause = 3;
      else if (mtie_in && mtip_in) int_cause = 7;
    end
    intr = (int_cause >= 0);

    e = '0;
    e.cause = 4'(m_cause);
    e.ioe   = m_ioe;
    e.mis   = m_mis;
    case (m_phase)
      "RESET":       begin e.pc_src = 2'b00; e.flush = 1; end
      "OPERATING":   begin e.pc_src = 2'b01; e.instret = !(exc || intr); end
      "TRAP_TAKEN":  begin e.pc_src = 2'b11; e.flush = 1;
                           e.set_cause = 1; e.set_epc = 1; e.mie_clear = 1; end
      default:       begin e.pc_src = 2'b10; e.flush = 1; e.mie_set = 1; end
    endcase
    expq.push_back(e);

    if (!rst_in) begin
      m_phase = "RESET"; m_cause = 0; m_ioe = 0; m_mis = 0;
    end else if (m_phase == "OPERATING") begin
      if (exc) begin
        m_phase = "TRAP_TAKEN"; m_cause = exc_cause; m_ioe = 0;
        m_mis = (exc_cause == 0 || exc_cause == 4 || exc_cause == 6);
      end else if (intr) begin
        m_phase = "TRAP_TAKEN"; m_cause = int_cause; m_ioe = 1; m_mis = 0;
      end else if (mret) m_phase = "TRAP_RETURN";
    end else m_phase = "OPERATING";
  endtask

  task automatic clear_in();
    {illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in} = '0;
    opcode_6_2_in = 5'b01100; funct3_in = 0; funct7_in = 0;
    rs1_addr_in = 0; rs2_addr_in = 0; rd_addr_in = 0;
    {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = '0;
  endtask

  task automatic set_sys(input logic [6:0] f7, input logic [4:0] rs2);
    opcode_6_2_in = 5'b11100; funct3_in = 0; funct7_in = f7;
    rs1_addr_in = 0; rs2_addr_in = rs2; rd_addr_in = 0;
  endtask

  // Inputs already applied; check and move one cycle on
  task automatic cyc();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rand_in();
    int k;
    clear_in();
    rst_in = ($urandom_range(0, 39) != 0);
    illegal_instr_in    = ($urandom_range(0, 9) == 0);
    misaligned_instr_in = ($urandom_range(0, 11) == 0);
    misaligned_load_in  = ($urandom_range(0, 9) == 0);
    misaligned_store_in = ($urandom_range(0, 9) == 0);
    k = $urandom_range(0, 7);
    case (k)
      0: set_sys(7'd0, 5'd0);
      1: set_sys(7'd0, 5'd1);
      2, 3: set_sys(7'b0011000, 5'b00010);
      4: begin
        opcode_6_2_in = 5'($urandom_range(0, 1) ? 5'b11100 : 5'($urandom));
        funct3_in = 3'($urandom_range(0, 1)); funct7_in = 7'($urandom);
        rs1_addr_in = 5'($urandom_range(0, 1)); rs2_addr_in = 5'($urandom_range(0, 2));
        rd_addr_in = 5'($urandom_range(0, 1));
      end
      default: opcode_6_2_in = 5'($urandom);
    endcase
    mie_in  = ($urandom_range(0, 2) == 0);
    {meie_in, mtie_in, msie_in} = 3'($urandom);
    {meip_in, mtip_in, msip_in} = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
  endtask

  initial begin
    int wait_cnt;
    clear_in();
    rst_in = 0;
    @(posedge clk_in); #1;
    // Reset held low for three checked cycles, then release
    repeat (3) cyc();
    rst_in = 1;
    cyc();              // RESET cycle after release
    cyc();              // OPERATING, plain instruction retires
    // ECALL
    set_sys(7'd0, 5'd0); cyc();
    clear_in(); cyc(); cyc();
    // illegal + misaligned_load -> cause 2
    illegal_instr_in = 1; misaligned_load_in = 1; cyc();
    clear_in(); cyc(); cyc();
    // misaligned_store alone -> cause 6
    misaligned_store_in = 1; cyc();
    clear_in(); cyc(); cyc();
    // interrupts: external beats timer
    mie_in = 1; meie_in = 1; meip_in = 1; mtie_in = 1; mtip_in = 1; cyc();
    mie_in = 0; cyc();  // TRAP_TAKEN, still pending but MIE clear
    cyc(); cyc();       // no re-entry
    // MRET
    clear_in(); set_sys(7'b0011000, 5'b00010); cyc();
    clear_in(); cyc(); cyc();
    // MRET with illegal -> trap cause 2
    set_sys(7'b0011000, 5'b00010); illegal_instr_in = 1; cyc();
    clear_in(); cyc(); cyc();
    // exception beats interrupt, EBREAK
    set_sys(7'd0, 5'd1); mie_in = 1; msie_in = 1; msip_in = 1; cyc();
    clear_in(); cyc(); cyc();
    // reset during TRAP_TAKEN
    set_sys(7'd0, 5'd0); cyc();
    clear_in(); rst_in = 0; cyc();
    rst_in = 1; cyc(); cyc(); cyc();
    // Randomized traffic
    repeat (600) begin rand_in(); cyc(); end
    clear_in(); rst_in = 1;
    wait_cnt = 0;
    while (expq.size() > 0 && wait_cnt < 20) begin
      @(posedge clk_in); wait_cnt++;
    end
    if (expq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout left=%0d want=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
